// File: rtl/seq_match_monitor.sv
// seq_match_monitor: BCD event/run statistics of the detector z stream, shown on six 7-seg digits.
// Statistics update on the edge that samples z (one register stage); HEX is combinational; never stalls z.
module seq_match_monitor #(
  parameter bit WRAP = 1'b0
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       z,
  input  logic       Clear,
  output logic [7:0] EventCount,
  output logic [7:0] RunLen,
  output logic [7:0] MaxRun,
  output logic       Pulse,
  output logic       Overflow,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  logic       z_prev;
  logic [7:0] ev_cnt;
  logic [7:0] run_len;
  logic [7:0] max_run;
  logic       pulse_q;
  logic       ovf_q;
  logic       rise;
  logic [7:0] run_len_next;

  // Two-digit BCD increment; 99 either holds or wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99)
      r = WRAP ? 8'h00 : 8'h99;
    else if (v[3:0] == 4'd9)
      r = {v[7:4] + 4'd1, 4'd0};
    else
      r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  always_comb begin
    rise         = z & ~z_prev;
    run_len_next = run_len;
    if (rise)
      run_len_next = 8'h01;
    else if (z)
      run_len_next = bcd_inc(run_len);
  end

  // Packed BCD with valid nibbles orders the same as binary, so a plain compare is tens-then-units.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      z_prev  <= 1'b0;
      ev_cnt  <= 8'h00;
      run_len <= 8'h00;
      max_run <= 8'h00;
      pulse_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (Clear) begin
      z_prev  <= z;
      ev_cnt  <= 8'h00;
      run_len <= 8'h00;
      max_run <= 8'h00;
      pulse_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      z_prev  <= z;
      pulse_q <= rise;
      run_len <= run_len_next;
      if (rise) begin
        ev_cnt <= bcd_inc(ev_cnt);
        if (ev_cnt == 8'h99)
          ovf_q <= 1'b1;
      end
      if (run_len_next > max_run)
        max_run <= run_len_next;
    end
  end

  assign EventCount = ev_cnt;
  assign RunLen     = run_len;
  assign MaxRun     = max_run;
  assign Pulse      = pulse_q;
  assign Overflow   = ovf_q;

  assign HEX0 = seg7(ev_cnt[3:0]);
  assign HEX1 = seg7(ev_cnt[7:4]);
  assign HEX2 = seg7(run_len[3:0]);
  assign HEX3 = seg7(run_len[7:4]);
  assign HEX4 = seg7(max_run[3:0]);
  assign HEX5 = seg7(max_run[7:4]);

endmodule
